// File: rtl/kmeans_centroid_update_k2n2.sv
// Centroid update for the k=2, n=2 k-means core: reads per-centroid sums/counts from the
// accumulator block, divides with restoring dividers, and tracks convergence. Option: KMEANS_UPDATE_ROUND_EN.
module kmeans_centroid_update_k2n2 #(
    parameter int input_data_width         = 8,
    parameter int input_data_qty_bit_width = 8,
    parameter int acc_width                = 16,
    parameter logic [input_data_width-1:0] k0_d0_initial = input_data_width'(0),
    parameter logic [input_data_width-1:0] k0_d1_initial = input_data_width'(0),
    parameter logic [input_data_width-1:0] k1_d0_initial = input_data_width'(1),
    parameter logic [input_data_width-1:0] k1_d1_initial = input_data_width'(1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [acc_width-1:0]                acc0_output,
    input  logic [acc_width-1:0]                acc1_output,
    input  logic [input_data_qty_bit_width-1:0] acc_counter_output,
    output logic                                rd_acc_en,
    output logic                                rd_acc_centroid,
    output logic [input_data_width-1:0]         new_k0d0,
    output logic [input_data_width-1:0]         new_k0d1,
    output logic [input_data_width-1:0]         new_k1d0,
    output logic [input_data_width-1:0]         new_k1d1,
    output logic                                busy,
    output logic                                done,
    output logic                                converged
);

`ifdef KMEANS_UPDATE_ROUND_EN
    localparam int div_width = acc_width + 1;
`else
    localparam int div_width = acc_width;
`endif
    localparam int rem_width  = acc_width + 1;
    localparam int iter_width = $clog2(div_width + 1);
    localparam logic [iter_width-1:0] last_iter = iter_width'(div_width - 1);

    typedef enum logic [2:0] {IDLE, ADDR, LATCH, DIV, WRITE, DONE} state_t;

    state_t                              state_q;
    logic                                c_q;
    logic                                changed_q;
    logic [input_data_qty_bit_width-1:0] cnt_q;
    logic [iter_width-1:0]               iter_q;
    logic [div_width-1:0]                dvd_q [2];
    logic [rem_width-1:0]                rem_q [2];
    logic [input_data_width-1:0]         cent_q [2][2];
    logic                                rd_acc_en_q;
    logic                                rd_acc_centroid_q;
    logic                                busy_q;
    logic                                done_q;
    logic                                converged_q;

    logic [acc_width-1:0]        acc_in [2];
    logic [rem_width-1:0]        divisor_ext;
    logic [div_width-1:0]        dvd_init [2];
    logic [div_width-1:0]        dvd_d [2];
    logic [rem_width-1:0]        rem_d [2];
    logic [input_data_width-1:0] wr_val [2];
    logic                        wr_diff [2];

    assign acc_in[0]   = acc0_output;
    assign acc_in[1]   = acc1_output;
    assign divisor_ext = rem_width'(cnt_q);

    // One restoring-divider step per dimension; the dividend register shifts the quotient in from the LSB.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dim
            logic [rem_width-1:0]        rem_shift;
            logic                        sub_ok;
            logic [input_data_width-1:0] quo_sat;

`ifdef KMEANS_UPDATE_ROUND_EN
            assign dvd_init[gi] = {1'b0, acc_in[gi]} + div_width'(acc_counter_output >> 1);
`else
            assign dvd_init[gi] = acc_in[gi];
`endif
            assign rem_shift = {rem_q[gi][rem_width-2:0], dvd_q[gi][div_width-1]};
            assign sub_ok    = (rem_shift >= divisor_ext);
            assign rem_d[gi] = sub_ok ? (rem_shift - divisor_ext) : rem_shift;
            assign dvd_d[gi] = {dvd_q[gi][div_width-2:0], sub_ok};

            assign quo_sat     = (|dvd_q[gi][div_width-1:input_data_width]) ? '1
                                                                            : dvd_q[gi][input_data_width-1:0];
            // An empty centroid keeps its previous position.
            assign wr_val[gi]  = (cnt_q == '0) ? cent_q[c_q][gi] : quo_sat;
            assign wr_diff[gi] = (wr_val[gi] != cent_q[c_q][gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= IDLE;
            c_q               <= 1'b0;
            changed_q         <= 1'b0;
            cnt_q             <= '0;
            iter_q            <= '0;
            for (int d = 0; d < 2; d++) begin
                dvd_q[d] <= '0;
                rem_q[d] <= '0;
            end
            cent_q[0][0]      <= k0_d0_initial;
            cent_q[0][1]      <= k0_d1_initial;
            cent_q[1][0]      <= k1_d0_initial;
            cent_q[1][1]      <= k1_d1_initial;
            rd_acc_en_q       <= 1'b0;
            rd_acc_centroid_q <= 1'b0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            converged_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        c_q               <= 1'b0;
                        rd_acc_en_q       <= 1'b1;
                        rd_acc_centroid_q <= 1'b0;
                        busy_q            <= 1'b1;
                        changed_q         <= 1'b0;
                        state_q           <= ADDR;
                    end
                end
                ADDR: state_q <= LATCH;
                LATCH: begin
                    cnt_q  <= acc_counter_output;
                    iter_q <= '0;
                    for (int d = 0; d < 2; d++) begin
                        dvd_q[d] <= dvd_init[d];
                        rem_q[d] <= '0;
                    end
                    state_q <= (acc_counter_output == '0) ? WRITE : DIV;
                end
                DIV: begin
                    for (int d = 0; d < 2; d++) begin
                        dvd_q[d] <= dvd_d[d];
                        rem_q[d] <= rem_d[d];
                    end
                    iter_q <= iter_q + 1'b1;
                    if (iter_q == last_iter) begin
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    for (int d = 0; d < 2; d++) begin
                        cent_q[c_q][d] <= wr_val[d];
                    end
                    if (wr_diff[0] || wr_diff[1]) begin
                        changed_q <= 1'b1;
                    end
                    if (c_q == 1'b0) begin
                        c_q               <= 1'b1;
                        rd_acc_centroid_q <= 1'b1;
                        state_q           <= ADDR;
                    end else begin
                        rd_acc_en_q <= 1'b0;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    done_q      <= 1'b1;
                    converged_q <= !changed_q;
                    rd_acc_en_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_acc_en       = rd_acc_en_q;
    assign rd_acc_centroid = rd_acc_centroid_q;
    assign new_k0d0        = cent_q[0][0];
    assign new_k0d1        = cent_q[0][1];
    assign new_k1d0        = cent_q[1][0];
    assign new_k1d1        = cent_q[1][1];
    assign busy            = busy_q;
    assign done            = done_q;
    assign converged       = converged_q;

endmodule

// File: tb/tb_kmeans_centroid_update_k2n2.sv
// Scoreboard bench for kmeans_centroid_update_k2n2: an array-based accumulator model feeds
// the read port, and expected centroids/convergence/latency come from plain integer arithmetic.
module tb_kmeans_centroid_update_k2n2;
    localparam int IW = 8;
    localparam int QW = 8;
    localparam int AW = 16;
`ifdef KMEANS_UPDATE_ROUND_EN
    localparam int ROUND = 1;
`else
    localparam int ROUND = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] acc0_output;
    logic [AW-1:0] acc1_output;
    logic [QW-1:0] acc_counter_output;
    logic          rd_acc_en;
    logic          rd_acc_centroid;
    logic [IW-1:0] new_k0d0, new_k0d1, new_k1d0, new_k1d1;
    logic          busy, done, converged;

    typedef struct {
        int k00;
        int k01;
        int k10;
        int k11;
        int conv;
        int lat;
        int issue;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   m_sum0[2];
    int   m_sum1[2];
    int   m_cnt[2];
    int   ref_k[2][2];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   txn_id = 0;

    kmeans_centroid_update_k2n2 dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .acc0_output       (acc0_output),
        .acc1_output       (acc1_output),
        .acc_counter_output(acc_counter_output),
        .rd_acc_en         (rd_acc_en),
        .rd_acc_centroid   (rd_acc_centroid),
        .new_k0d0          (new_k0d0),
        .new_k0d1          (new_k0d1),
        .new_k1d0          (new_k1d0),
        .new_k1d1          (new_k1d1),
        .busy              (busy),
        .done              (done),
        .converged         (converged)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Accumulator read port model: combinational on the requested centroid index.
    assign acc0_output        = AW'(m_sum0[rd_acc_centroid]);
    assign acc1_output        = AW'(m_sum1[rd_acc_centroid]);
    assign acc_counter_output = QW'(m_cnt[rd_acc_centroid]);

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic ref_reset();
        ref_k[0][0] = 0;
        ref_k[0][1] = 0;
        ref_k[1][0] = 1;
        ref_k[1][1] = 1;
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", int'(done), 0);
            end else begin
                mon_e = exp_q.pop_front();
                $display("done: k0=(%0d,%0d) k1=(%0d,%0d) conv=%0d latency=%0d",
                         new_k0d0, new_k0d1, new_k1d0, new_k1d1, converged, cyc - mon_e.issue);
                chk("new_k0d0", int'(new_k0d0), mon_e.k00);
                chk("new_k0d1", int'(new_k0d1), mon_e.k01);
                chk("new_k1d0", int'(new_k1d0), mon_e.k10);
                chk("new_k1d1", int'(new_k1d1), mon_e.k11);
                chk("converged", int'(converged), mon_e.conv);
                chk("latency", cyc - mon_e.issue, mon_e.lat);
                chk("busy_at_done", int'(busy), 0);
            end
        end
    end

    // Loads the accumulator model, predicts the result, pulses start and optionally
    // re-pulses start while busy (extra = cycles after start, -1 = random, 0 = none).
    task automatic run_txn(input int s00, input int s01, input int c0,
                           input int s10, input int s11, input int c1, input int extra);
        exp_t e;
        int   sums[2][2];
        int   cnts[2];
        int   lat;
        int   q;
        int   n;
        int   ex;
        bit   ch;
        sums[0][0] = s00; sums[0][1] = s01; cnts[0] = c0;
        sums[1][0] = s10; sums[1][1] = s11; cnts[1] = c1;
        for (int c = 0; c < 2; c++) begin
            m_sum0[c] = sums[c][0];
            m_sum1[c] = sums[c][1];
            m_cnt[c]  = cnts[c];
        end
        ch  = 1'b0;
        lat = 7;
        for (int c = 0; c < 2; c++) begin
            if (cnts[c] != 0) begin
                lat += AW + ROUND;
                for (int d = 0; d < 2; d++) begin
                    q = (sums[c][d] + ROUND * (cnts[c] / 2)) / cnts[c];
                    if (q > 255) q = 255;
                    if (q != ref_k[c][d]) ch = 1'b1;
                    ref_k[c][d] = q;
                end
            end
        end
        e.k00  = ref_k[0][0];
        e.k01  = ref_k[0][1];
        e.k10  = ref_k[1][0];
        e.k11  = ref_k[1][1];
        e.conv = ch ? 0 : 1;
        e.lat  = lat;
        ex = (extra < 0) ? ($urandom_range(0, 1) == 1 ? int'($urandom_range(1, lat - 1)) : 0) : extra;
        txn_id++;
        $display("txn %0d: c0=(%0d,%0d,n=%0d) c1=(%0d,%0d,n=%0d) extra_start=%0d exp k0=(%0d,%0d) k1=(%0d,%0d) conv=%0d lat=%0d",
                 txn_id, s00, s01, c0, s10, s11, c1, ex, e.k00, e.k01, e.k10, e.k11, e.conv, lat);
        @(negedge clk);
        e.issue = cyc + 1;
        exp_q.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (ex > 0) begin
            repeat (ex) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        chk("idle_busy", int'(busy), 0);
    endtask

    function automatic int rnd_sum();
        return int'($urandom_range(0, 65535) >> $urandom_range(0, 15));
    endfunction

    function automatic int rnd_cnt();
        return ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 255));
    endfunction

    initial begin
        int a0, a1, a2, b0, b1, b2;
        rst   = 1'b1;
        start = 1'b0;
        for (int c = 0; c < 2; c++) begin
            m_sum0[c] = 0;
            m_sum1[c] = 0;
            m_cnt[c]  = 0;
        end
        ref_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_k0d0", int'(new_k0d0), 0);
        chk("reset_k0d1", int'(new_k0d1), 0);
        chk("reset_k1d0", int'(new_k1d0), 1);
        chk("reset_k1d1", int'(new_k1d1), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_rd_acc_en", int'(rd_acc_en), 0);
        chk("reset_converged", int'(converged), 0);

        run_txn(100, 50, 10, 300, 90, 3, 0);
        run_txn(100, 50, 10, 300, 90, 3, 0);
        run_txn(1000, 7, 2, 55, 66, 0, 0);
        run_txn(100, 50, 10, 300, 90, 3, 10);
        run_txn(200, 20, 4, 30, 60, 6, 2 * (AW + ROUND) + 6);

        a0 = 0; a1 = 0; a2 = 0; b0 = 0; b1 = 0; b2 = 0;
        for (int i = 0; i < 20; i++) begin
            if (i % 5 != 4) begin
                a0 = rnd_sum(); a1 = rnd_sum(); a2 = rnd_cnt();
                b0 = rnd_sum(); b1 = rnd_sum(); b2 = rnd_cnt();
            end
            run_txn(a0, a1, a2, b0, b1, b2, -1);
        end

        // Reset in the middle of the first divide: no done, everything back to initial values.
        m_sum0[0] = 500; m_sum1[0] = 400; m_cnt[0] = 5;
        m_sum0[1] = 90;  m_sum1[1] = 80;  m_cnt[1] = 9;
        $display("txn %0d: reset asserted mid-divide", ++txn_id);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_rd_acc_en", int'(rd_acc_en), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_k0d0", int'(new_k0d0), 0);
        chk("midrst_k0d1", int'(new_k0d1), 0);
        chk("midrst_k1d0", int'(new_k1d0), 1);
        chk("midrst_k1d1", int'(new_k1d1), 1);
        rst = 1'b0;
        ref_reset();
        repeat (60) @(negedge clk);
        chk("midrst_stays_idle", int'(busy), 0);
        run_txn(500, 400, 5, 90, 80, 9, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
